// File: rtl/sse_pkg.sv
// rtl/sse_pkg.sv - shared types for the SSE pair feeder
package sse_pkg;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    logic  last;
    fp32_t a;
    fp32_t b;
  } sse_pair_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/sse_pair_fifo.sv
// rtl/sse_pair_fifo.sv - synchronous FIFO of sse_pair_t with show-ahead read data
module sse_pair_fifo
  import sse_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  sse_pair_t              wr_data,
  input  logic                   pop,
  output sse_pair_t              rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  sse_pair_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sse_pair_feeder.sv
// rtl/sse_pair_feeder.sv - buffers (a,b) pairs and presents them to the SSE unit on next-strobe edges
// Optional SSE_FEEDER_PAIRCNT_EN adds a saturating per-stream pair_count output.
module sse_pair_feeder
  import sse_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_a,
  input  logic [31:0] wr_b,
  input  logic        wr_last,
  input  logic        next,
  input  logic        sse_ready,
  input  logic [31:0] sse_y,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        stop,
  output logic        res_valid,
  output logic [31:0] res_y,
`ifdef SSE_FEEDER_PAIRCNT_EN
  output logic [15:0] pair_count,
`endif
  output logic        underrun
);

  localparam int CW = $clog2(DEPTH) + 1;

  feeder_state_t   state, state_d;
  sse_pair_t       head;
  sse_pair_t       wr_pair;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            next_q;
  logic            adv;
  logic            pop;
  logic            prime;
  logic            set_underrun;
  logic            capture;

  assign wr_pair  = '{last: wr_last, a: wr_a, b: wr_b};
  assign wr_ready = (fifo_count < CW'(DEPTH));
  assign adv      = next & ~next_q;

  sse_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_valid & ~fifo_full),
    .wr_data (wr_pair),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d      = state;
    pop          = 1'b0;
    prime        = 1'b0;
    set_underrun = 1'b0;
    capture      = 1'b0;
    case (state)
      // First pair of a stream is loaded without waiting for a strobe.
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          prime   = 1'b1;
          state_d = head.last ? LAST : RUN;
        end
      end
      RUN: begin
        if (adv) begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head.last) state_d = LAST;
          end else begin
            set_underrun = 1'b1;
          end
        end
      end
      LAST: begin
        if (sse_ready) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      next_q    <= 1'b0;
      A         <= '0;
      B         <= '0;
      stop      <= 1'b0;
      res_valid <= 1'b0;
      res_y     <= '0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_d;
      next_q    <= next;
      res_valid <= capture;
      if (pop) begin
        A    <= head.a;
        B    <= head.b;
        stop <= head.last;
      end
      if (capture) begin
        res_y <= sse_y;
        stop  <= 1'b0;
      end
      if (set_underrun) underrun <= 1'b1;
    end
  end

`ifdef SSE_FEEDER_PAIRCNT_EN
  // The priming pop starts a new stream, so the count restarts at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_count <= '0;
    end else if (prime) begin
      pair_count <= 16'd1;
    end else if (pop && pair_count != 16'hFFFF) begin
      pair_count <= pair_count + 16'd1;
    end
  end
`endif

endmodule
